// File: rtl/ex_unit_p_if.sv
// ex_unit_p_if: instruction-in / result-out bundle between the pipeline and the execute stage
interface ex_unit_p_if #(parameter int DATA_W = 32, parameter int ADDR_W = 5);
  logic              flush_i;
  logic              valid_i;
  logic [3:0]        aluop_i;
  logic [DATA_W-1:0] reg1_i;
  logic [DATA_W-1:0] reg2_i;
  logic [ADDR_W-1:0] wd_i;
  logic              wreg_i;
  logic              valid_o;
  logic [ADDR_W-1:0] wd_o;
  logic              wreg_o;
  logic [DATA_W-1:0] wdata_o;
  logic              whilo_o;
  logic [DATA_W-1:0] hi_o;
  logic [DATA_W-1:0] lo_o;
  logic              stallreq_o;
  modport master (
    output flush_i, valid_i, aluop_i, reg1_i, reg2_i, wd_i, wreg_i,
    input  valid_o, wd_o, wreg_o, wdata_o, whilo_o, hi_o, lo_o, stallreq_o
  );
  modport slave (
    input  flush_i, valid_i, aluop_i, reg1_i, reg2_i, wd_i, wreg_i,
    output valid_o, wd_o, wreg_o, wdata_o, whilo_o, hi_o, lo_o, stallreq_o
  );
endinterface

// File: rtl/ex_unit_p.sv
// ex_unit_p: single-cycle ALU plus iterative restoring divider, results registered at EX/MEM
module ex_unit_p #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input logic         clk,
  input logic         rst,
  ex_unit_p_if.slave  ex
);
  localparam int SW = $clog2(DATA_W);
  typedef enum logic [1:0] {IDLE, DIV, DONE} state_t;
  state_t state_q, state_d;
  logic [SW-1:0] count_q, count_d;
  logic [DATA_W-1:0] rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
  logic a_neg_q, a_neg_d, q_neg_q, q_neg_d, zero_q, zero_d;
  logic [ADDR_W-1:0] dwd_q, dwd_d;
  logic valid_q, valid_d, wreg_q, wreg_d, whilo_q, whilo_d;
  logic [ADDR_W-1:0] wd_q, wd_d;
  logic [DATA_W-1:0] wdata_q, wdata_d, hi_q, hi_d, lo_q, lo_d;
  logic [DATA_W-1:0] a, b, res, sra, abs_a, abs_b, rem_next, quo_next, q_fin, r_fin;
  logic [SW-1:0] shamt;
  logic [DATA_W:0] shifted, diff;
  logic is_div, sgn, a_neg_in, b_neg_in, ge;
  assign a = ex.reg1_i;
  assign b = ex.reg2_i;
  assign shamt = b[SW-1:0];
  assign sra = $signed(a) >>> shamt;
  assign is_div = ex.aluop_i == 4'd11 || ex.aluop_i == 4'd12;
  assign sgn = ex.aluop_i == 4'd11;
  assign a_neg_in = sgn & a[DATA_W-1];
  assign b_neg_in = sgn & b[DATA_W-1];
  assign abs_a = a_neg_in ? -a : a;
  assign abs_b = b_neg_in ? -b : b;
  assign res = ex.aluop_i == 4'd0  ? a | b :
               ex.aluop_i == 4'd1  ? a & b :
               ex.aluop_i == 4'd2  ? a ^ b :
               ex.aluop_i == 4'd3  ? ~(a | b) :
               ex.aluop_i == 4'd4  ? a << shamt :
               ex.aluop_i == 4'd5  ? a >> shamt :
               ex.aluop_i == 4'd6  ? sra :
               ex.aluop_i == 4'd7  ? a + b :
               ex.aluop_i == 4'd8  ? a - b :
               ex.aluop_i == 4'd9  ? {{(DATA_W-1){1'b0}}, $signed(a) < $signed(b)} :
               ex.aluop_i == 4'd10 ? {{(DATA_W-1){1'b0}}, a < b} : '0;
  // one restoring step: the partial remainder never exceeds DATA_W bits once reduced
  assign shifted = {rem_q, quo_q[DATA_W-1]};
  assign diff = shifted - {1'b0, dvs_q};
  assign ge = ~diff[DATA_W];
  assign rem_next = ge ? diff[DATA_W-1:0] : shifted[DATA_W-1:0];
  assign quo_next = {quo_q[DATA_W-2:0], ge};
  assign q_fin = zero_q ? '1 : q_neg_q ? -quo_q : quo_q;
  assign r_fin = a_neg_q ? -rem_q : rem_q;
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    rem_d = rem_q;
    quo_d = quo_q;
    dvs_d = dvs_q;
    a_neg_d = a_neg_q;
    q_neg_d = q_neg_q;
    zero_d = zero_q;
    dwd_d = dwd_q;
    valid_d = 1'b0;
    wreg_d = 1'b0;
    whilo_d = 1'b0;
    wd_d = wd_q;
    wdata_d = wdata_q;
    hi_d = hi_q;
    lo_d = lo_q;
    if (state_q == IDLE && ex.valid_i) begin
      if (is_div) begin
        state_d = DIV;
        count_d = '0;
        rem_d = '0;
        quo_d = abs_a;
        dvs_d = abs_b;
        a_neg_d = a_neg_in;
        q_neg_d = a_neg_in ^ b_neg_in;
        zero_d = b == '0;
        dwd_d = ex.wd_i;
      end else begin
        valid_d = 1'b1;
        wreg_d = ex.wreg_i;
        wd_d = ex.wd_i;
        wdata_d = res;
      end
    end else if (state_q == DIV) begin
      rem_d = rem_next;
      quo_d = quo_next;
      count_d = count_q + 1'b1;
      state_d = count_q == SW'(DATA_W-1) ? DONE : DIV;
    end else if (state_q == DONE) begin
      state_d = IDLE;
      valid_d = 1'b1;
      whilo_d = 1'b1;
      wd_d = dwd_q;
      hi_d = r_fin;
      lo_d = q_fin;
    end
    if (ex.flush_i) begin
      state_d = IDLE;
      count_d = '0;
      valid_d = 1'b0;
      wreg_d = 1'b0;
      whilo_d = 1'b0;
      wd_d = wd_q;
      wdata_d = wdata_q;
      hi_d = hi_q;
      lo_d = lo_q;
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      count_q <= '0;
      rem_q <= '0;
      quo_q <= '0;
      dvs_q <= '0;
      a_neg_q <= 1'b0;
      q_neg_q <= 1'b0;
      zero_q <= 1'b0;
      dwd_q <= '0;
      valid_q <= 1'b0;
      wreg_q <= 1'b0;
      whilo_q <= 1'b0;
      wd_q <= '0;
      wdata_q <= '0;
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      rem_q <= rem_d;
      quo_q <= quo_d;
      dvs_q <= dvs_d;
      a_neg_q <= a_neg_d;
      q_neg_q <= q_neg_d;
      zero_q <= zero_d;
      dwd_q <= dwd_d;
      valid_q <= valid_d;
      wreg_q <= wreg_d;
      whilo_q <= whilo_d;
      wd_q <= wd_d;
      wdata_q <= wdata_d;
      hi_q <= hi_d;
      lo_q <= lo_d;
    end
  end
  assign ex.stallreq_o = rst & ((state_q == IDLE & ex.valid_i & is_div) | state_q == DIV);
  assign ex.valid_o = valid_q;
  assign ex.wreg_o = wreg_q;
  assign ex.whilo_o = whilo_q;
  assign ex.wd_o = wd_q;
  assign ex.wdata_o = wdata_q;
  assign ex.hi_o = hi_q;
  assign ex.lo_o = lo_q;
endmodule

// File: tb/tb_ex_unit_p.sv
// tb_ex_unit_p: directed vectors against 32-bit and 16-bit ex_unit_p instances
module tb_ex_unit_p;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int vecs = 0;
  int errs = 0;
  always #5 clk = ~clk;
  ex_unit_p_if #(.DATA_W(32), .ADDR_W(5)) i32 ();
  ex_unit_p_if #(.DATA_W(16), .ADDR_W(5)) i16 ();
  ex_unit_p #(.DATA_W(32), .ADDR_W(5)) u32 (.clk(clk), .rst(rst), .ex(i32.slave));
  ex_unit_p #(.DATA_W(16), .ADDR_W(5)) u16 (.clk(clk), .rst(rst), .ex(i16.slave));
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h, want %h", tag, got, exp);
    end
  endtask
  task automatic drive(input bit w16, input logic v, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    if (w16) begin
      i16.valid_i = v;
      i16.aluop_i = op;
      i16.reg1_i = a[15:0];
      i16.reg2_i = b[15:0];
      i16.wd_i = 5'(op) + 5'd1;
      i16.wreg_i = 1'b1;
    end else begin
      i32.valid_i = v;
      i32.aluop_i = op;
      i32.reg1_i = a;
      i32.reg2_i = b;
      i32.wd_i = 5'(op) + 5'd1;
      i32.wreg_i = 1'b1;
    end
  endtask
  task automatic op1(input bit w16, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] exp, input string tag);
    drive(w16, 1'b1, op, a, b);
    @(negedge clk);
    check(tag, w16 ? {16'h0, i16.wdata_o} : i32.wdata_o, exp);
    check({tag, "_valid"}, w16 ? i16.valid_o : i32.valid_o, 1'b1);
    check({tag, "_wreg"}, w16 ? i16.wreg_o : i32.wreg_o, 1'b1);
    check({tag, "_wd"}, w16 ? i16.wd_o : i32.wd_o, 5'(op) + 5'd1);
  endtask
  task automatic div(input bit w16, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] lo_e, input logic [31:0] hi_e, input int stall_e, input string tag);
    int n = 0;
    drive(w16, 1'b1, op, a, b);
    #1;
    while ((w16 ? i16.stallreq_o : i32.stallreq_o) && n < 200) begin
      n++;
      @(negedge clk);
    end
    check({tag, "_stall"}, n, stall_e);
    drive(w16, 1'b0, 4'd0, 0, 0);
    @(negedge clk);
    check({tag, "_valid"}, w16 ? i16.valid_o : i32.valid_o, 1'b1);
    check({tag, "_whilo"}, w16 ? i16.whilo_o : i32.whilo_o, 1'b1);
    check({tag, "_wreg"}, w16 ? i16.wreg_o : i32.wreg_o, 1'b0);
    check({tag, "_wd"}, w16 ? i16.wd_o : i32.wd_o, 5'(op) + 5'd1);
    check({tag, "_lo"}, w16 ? {16'h0, i16.lo_o} : i32.lo_o, lo_e);
    check({tag, "_hi"}, w16 ? {16'h0, i16.hi_o} : i32.hi_o, hi_e);
    @(negedge clk);
    check({tag, "_pulse"}, w16 ? i16.valid_o : i32.valid_o, 1'b0);
    check({tag, "_whilo_off"}, w16 ? i16.whilo_o : i32.whilo_o, 1'b0);
  endtask
  initial begin
    i32.flush_i = 1'b0;
    i16.flush_i = 1'b0;
    drive(0, 1'b0, 4'd0, 0, 0);
    drive(1, 1'b0, 4'd0, 0, 0);
    #2;
    check("rst_valid", i32.valid_o, 1'b0);
    check("rst_wdata", i32.wdata_o, 32'h0);
    check("rst_lohi", {i32.lo_o[15:0], i32.hi_o[15:0]}, 32'h0);
    check("rst_stall", i32.stallreq_o, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    op1(0, 4'd7, 32'h7FFFFFFF, 32'h1, 32'h80000000, "add");
    op1(0, 4'd8, 32'h0, 32'h1, 32'hFFFFFFFF, "sub");
    op1(0, 4'd9, 32'hFFFFFFFF, 32'h1, 32'h1, "slt");
    op1(0, 4'd10, 32'hFFFFFFFF, 32'h1, 32'h0, "sltu");
    op1(0, 4'd6, 32'h80000000, 32'h4, 32'hF8000000, "sra");
    op1(0, 4'd4, 32'h1, 32'd31, 32'h80000000, "sll");
    op1(0, 4'd5, 32'h80000000, 32'd31, 32'h1, "srl");
    op1(0, 4'd3, 32'h0F0F0000, 32'h000000F0, 32'hF0F0FF0F, "nor");
    op1(0, 4'd14, 32'h12345678, 32'h1, 32'h0, "op14");
    op1(0, 4'd5, 32'h80000000, 32'd31, 32'h1, "srl2");
    drive(0, 1'b0, 4'd0, 0, 0);
    @(negedge clk);
    check("idle_valid", i32.valid_o, 1'b0);
    check("idle_hold", i32.wdata_o, 32'h1);
    div(0, 4'd11, 32'hFFFFFFF9, 32'h2, 32'hFFFFFFFD, 32'hFFFFFFFF, 33, "div_m7_2");
    div(0, 4'd12, 32'hFFFFFFFF, 32'h10, 32'h0FFFFFFF, 32'hF, 33, "divu_big");
    div(0, 4'd12, 32'd5, 32'd0, 32'hFFFFFFFF, 32'd5, 33, "divu_zero");
    div(0, 4'd11, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h0, 33, "div_ovf");
    drive(0, 1'b1, 4'd11, 32'd1000, 32'd3);
    repeat (11) @(negedge clk);
    i32.flush_i = 1'b1;
    drive(0, 1'b0, 4'd0, 0, 0);
    @(negedge clk);
    check("flush_stall", i32.stallreq_o, 1'b0);
    check("flush_valid", i32.valid_o, 1'b0);
    check("flush_whilo", i32.whilo_o, 1'b0);
    drive(0, 1'b1, 4'd7, 32'd1, 32'd2);
    @(negedge clk);
    check("flush_drop_valid", i32.valid_o, 1'b0);
    check("flush_drop_hold", i32.wdata_o, 32'h1);
    i32.flush_i = 1'b0;
    op1(0, 4'd0, 32'hF0, 32'h0F, 32'hFF, "or_after_flush");
    drive(0, 1'b1, 4'd11, 32'd1000, 32'd3);
    repeat (6) @(negedge clk);
    rst = 1'b0;
    #1;
    check("mrst_valid", i32.valid_o, 1'b0);
    check("mrst_wdata", i32.wdata_o, 32'h0);
    check("mrst_lo", i32.lo_o, 32'h0);
    check("mrst_hi", i32.hi_o, 32'h0);
    check("mrst_wd", i32.wd_o, 32'h0);
    check("mrst_stall", i32.stallreq_o, 1'b0);
    drive(0, 1'b0, 4'd0, 0, 0);
    @(negedge clk);
    rst = 1'b1;
    div(0, 4'd12, 32'd100, 32'd7, 32'd14, 32'd2, 33, "divu_after_rst");
    op1(1, 4'd7, 32'h7FFF, 32'h1, 32'h8000, "add16");
    op1(1, 4'd8, 32'h0, 32'h1, 32'hFFFF, "sub16");
    op1(1, 4'd9, 32'hFFFF, 32'h1, 32'h1, "slt16");
    op1(1, 4'd10, 32'hFFFF, 32'h1, 32'h0, "sltu16");
    drive(1, 1'b0, 4'd0, 0, 0);
    @(negedge clk);
    div(1, 4'd11, 32'hFFF9, 32'h2, 32'hFFFD, 32'hFFFF, 17, "div16");
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
